// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO registers for the EX stage: fixed-latency mult/div, mthi/mtlo.
// Optional MADD/MADDU accumulate (ops 6/7) is built only when MD_MADD_EN is defined.
module md_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  // state_q is the probe point for FSM checkers
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
  state_t state_q, state_d;

  logic [CW-1:0]      cnt_q;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic               launch_op, launch, commit, mt_write;

  always_comb begin
    launch_op = (op[2] == 1'b0);
`ifdef MD_MADD_EN
    launch_op = launch_op | (op[2:1] == 2'b11);
`endif
  end

  // Handshake: start is a one-cycle request sampled only in IDLE; busy is high
  // from the cycle after launch until results are committed to hi/lo.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && launch_op) state_d = RUN;
      RUN:     if (cnt_q == CW'(1))    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q == RUN);
    launch   = (state_q == IDLE) && start && launch_op;
    commit   = (state_q == RUN) && (cnt_q == CW'(1));
    mt_write = (state_q == IDLE) && start && (op[2:1] == 2'b10);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else if (launch) begin
      op_q  <= op;
      a_q   <= a;
      b_q   <= b;
      cnt_q <= (op[2:1] == 2'b01) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
    end else if (busy) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  // Even ops (MULT, DIV, MADD) are signed, odd ones unsigned.
  logic                 sgn;
  logic [2*WIDTH-1:0]   ext_a, ext_b, prod;
  logic [WIDTH-1:0]     abs_a, abs_b, uq, ur, quo, rem;

  always_comb begin
    sgn   = ~op_q[0];
    ext_a = {{WIDTH{sgn & a_q[WIDTH-1]}}, a_q};
    ext_b = {{WIDTH{sgn & b_q[WIDTH-1]}}, b_q};
    prod  = ext_a * ext_b;
    // Divide on magnitudes so the most-negative / -1 case wraps cleanly
    abs_a = (sgn && a_q[WIDTH-1]) ? -a_q : a_q;
    abs_b = (sgn && b_q[WIDTH-1]) ? -b_q : b_q;
    uq    = (b_q == '0) ? '0 : abs_a / abs_b;
    ur    = (b_q == '0) ? '0 : abs_a % abs_b;
    quo   = (sgn && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -uq : uq;
    rem   = (sgn && a_q[WIDTH-1]) ? -ur : ur;
  end

`ifdef MD_MADD_EN
  logic [2*WIDTH-1:0] acc;
  assign acc = {hi, lo} + prod;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (commit) begin
      if (op_q[2:1] == 2'b00) begin
        {hi, lo} <= prod;
      end else if (op_q[2:1] == 2'b01) begin
        if (b_q != '0) begin
          hi <= rem;
          lo <= quo;
        end
      end
`ifdef MD_MADD_EN
      else begin
        {hi, lo} <= acc;
      end
`endif
    end else if (mt_write) begin
      if (op[0]) lo <= a;
      else       hi <= a;
    end
  end

  // The stall controller must never issue a new request while one is running.
  start_while_busy: assert property (@(posedge clk) disable iff (rst) !(start && busy))
    else $warning("md_unit: start while busy was ignored");

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: per-cycle compare against an arithmetic model of hi/lo/busy,
// plus hand-computed literal expectations for each scenario.
module tb_md_unit;
  localparam int W = 32;
`ifdef MD_MADD_EN
  localparam bit MADD_EN = 1'b1;
`else
  localparam bit MADD_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   op = '0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy;
  logic [W-1:0] hi, lo;

  int n_cmp = 0;
  int n_bad = 0;
  int n;

  // clock / reset
  always #5 clk = ~clk;

  md_unit #(.WIDTH(W), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .hi(hi), .lo(lo)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // behavioural model
  logic [W-1:0] m_hi = '0, m_lo = '0, p_a = '0, p_b = '0;
  logic [2:0]   p_op = '0;
  int           m_left = 0;

  function automatic logic [2*W-1:0] model_result(input logic [2:0] o, input logic [W-1:0] x,
                                                  input logic [W-1:0] y, input logic [2*W-1:0] hl);
    longint sx, sy;
    logic [2*W-1:0] ux, uy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    case (o)
      3'd0: return sx * sy;
      3'd1: return ux * uy;
      3'd2: if (y == 0) return hl; else return {32'(sx % sy), 32'(sx / sy)};
      3'd3: if (y == 0) return hl; else return {x % y, x / y};
      3'd6: return hl + 64'(sx * sy);
      3'd7: return hl + ux * uy;
      default: return hl;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_hi = '0; m_lo = '0; m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) {m_hi, m_lo} = model_result(p_op, p_a, p_b, {m_hi, m_lo});
    end else if (start) begin
      if (op <= 3 || (MADD_EN && op >= 6)) begin
        p_op = op; p_a = a; p_b = b;
        m_left = (op == 2 || op == 3) ? 10 : 5;
      end else if (op == 4) begin
        m_hi = a;
      end else if (op == 5) begin
        m_lo = a;
      end
    end
  end

  // scoreboard compare, every cycle outside reset
  always @(negedge clk) begin
    if (!rst) begin
      check("busy_model", W'(busy), W'(m_left > 0));
      check("hi_model", hi, m_hi);
      check("lo_model", lo, m_lo);
    end
  end

  // driver tasks
  task automatic pulse(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk); #1;
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
  endtask

  task automatic count_busy(output int cnt);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (!busy) break;
      cnt++;
      @(negedge clk); #1;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    check("reset_busy", W'(busy), 0);
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);

    pulse(3'd0, 32'hFFFF_FFFE, 32'd3);
    check("mult_hold_hi", hi, 0);
    check("mult_hold_lo", lo, 0);
    count_busy(n);
    check("mult_len", n, 5);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFA);

    pulse(3'd1, 32'hFFFF_FFFF, 32'd2);
    count_busy(n);
    check("multu_len", n, 5);
    check("multu_hi", hi, 32'h0000_0001);
    check("multu_lo", lo, 32'hFFFF_FFFE);

    pulse(3'd2, 32'hFFFF_FFF9, 32'd2);
    count_busy(n);
    check("div_len", n, 10);
    check("div_hi", hi, 32'hFFFF_FFFF);
    check("div_lo", lo, 32'hFFFF_FFFD);

    pulse(3'd3, 32'd7, 32'd0);
    count_busy(n);
    check("divu0_len", n, 10);
    check("divu0_hi", hi, 32'hFFFF_FFFF);
    check("divu0_lo", lo, 32'hFFFF_FFFD);

    pulse(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    count_busy(n);
    check("divovf_hi", hi, 32'h0000_0000);
    check("divovf_lo", lo, 32'h8000_0000);

    pulse(3'd4, 32'h1234_5678, 32'd0);
    count_busy(n);
    check("mthi_len", n, 0);
    check("mthi_hi", hi, 32'h1234_5678);
    check("mthi_lo", lo, 32'h8000_0000);

    pulse(3'd2, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_busy", W'(busy), 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    #1 rst = 1'b0;
    repeat (15) @(negedge clk);
    #1;
    check("rst_nocommit_hi", hi, 0);
    check("rst_nocommit_lo", lo, 0);

    pulse(3'd1, 32'd3, 32'd4);
    @(negedge clk); #1;
    start = 1'b1; op = 3'd0; a = 32'd9; b = 32'd9;
    repeat (2) @(negedge clk);
    #1 start = 1'b0;
    count_busy(n);
    check("ignore_len", n, 2);
    check("ignore_hi", hi, 0);
    check("ignore_lo", lo, 32'd12);

    pulse(3'd5, 32'd10, 32'd0);
    check("mtlo_lo", lo, 32'd10);
    pulse(3'd6, 32'hFFFF_FFFE, 32'd3);
    count_busy(n);
`ifdef MD_MADD_EN
    check("madd_len", n, 5);
    check("madd_hi", hi, 0);
    check("madd_lo", lo, 32'd4);
`else
    check("madd_len", n, 0);
    check("madd_hi", hi, 0);
    check("madd_lo", lo, 32'd10);
    pulse(3'd7, 32'd5, 32'd5);
    count_busy(n);
    check("maddu_len", n, 0);
    check("maddu_lo", lo, 32'd10);
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
